// File: rtl/pit_table.sv
// Pending Interest Table: fully-associative store of outstanding interests, FIB forwarding
// of new names, and the responder side of the FIB data-validation/payload handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for prefix_ready_i; captures the data prefix
// S_LOOKUP  | compares the captured prefix against all valid slots
// S_RESPOND | pulses rejected or start_send_to_pit; clears the hit slot
// S_RECEIVE | captures DATA_BYTES payload bytes from out_data_i
module pit_table #(
    parameter int ENTRIES    = 8,
    parameter int DATA_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        interest_valid_i,
    input  logic [63:0] interest_prefix_i,
    input  logic [5:0]  interest_len_i,
    output logic        interest_ready_o,
    output logic        fib_out_bit_o,
    output logic [63:0] pit_in_prefix_o,
    output logic [5:0]  pit_in_len_o,
    input  logic        prefix_ready_i,
    input  logic [63:0] pit_out_prefix_i,
    input  logic [5:0]  pit_out_len_i,
    input  logic [7:0]  out_data_i,
    output logic        rejected_o,
    output logic        start_send_to_pit_o,
    output logic [7:0]  data_out_o,
    output logic        data_out_valid_o,
    output logic        data_done_o
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(DATA_BYTES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESPOND, S_RECEIVE} state_t;

    state_t              state_q, state_d;
    logic [ENTRIES-1:0]  valid_q;
    logic [63:0]         prefix_q [ENTRIES];
    logic [5:0]          len_q    [ENTRIES];
    logic                fwd_q;
    logic [63:0]         fwd_prefix_q;
    logic [5:0]          fwd_len_q;
    logic [63:0]         qry_prefix_q;
    logic [5:0]          qry_len_q;
    logic                hit_q;
    logic [IW-1:0]       hit_idx_q;
    logic [CW-1:0]       cnt_q;
    logic [7:0]          data_q;
    logic                dv_q;
    logic                done_q;

    logic                ins_match, free_found, accept, alloc;
    logic [IW-1:0]       free_idx;
    logic                lk_hit;
    logic [IW-1:0]       lk_idx;
    logic                clear_slot, capture, last_byte;

    assign interest_ready_o    = ~&valid_q;
    assign accept              = interest_valid_i && interest_ready_o;
    assign alloc               = accept && !ins_match;
    assign fib_out_bit_o       = fwd_q;
    assign pit_in_prefix_o     = fwd_prefix_q;
    assign pit_in_len_o        = fwd_len_q;
    assign data_out_o          = data_q;
    assign data_out_valid_o    = dv_q;
    assign data_done_o         = done_q;

    always_comb begin
        ins_match  = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        lk_hit     = 1'b0;
        lk_idx     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && prefix_q[i] == interest_prefix_i && len_q[i] == interest_len_i)
                ins_match = 1'b1;
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (valid_q[i] && prefix_q[i] == qry_prefix_q && len_q[i] == qry_len_q) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        rejected_o          = 1'b0;
        start_send_to_pit_o = 1'b0;
        clear_slot          = 1'b0;
        capture             = 1'b0;
        last_byte           = 1'b0;
        case (state_q)
            S_IDLE:    if (prefix_ready_i) state_d = S_LOOKUP;
            S_LOOKUP:  state_d = S_RESPOND;
            S_RESPOND: begin
                if (hit_q) begin
                    start_send_to_pit_o = 1'b1;
                    clear_slot          = 1'b1;
                    state_d             = S_RECEIVE;
                end else begin
                    rejected_o = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_RECEIVE: begin
                capture   = 1'b1;
                last_byte = (cnt_q == CW'(DATA_BYTES - 1));
                if (last_byte) state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Allocation only ever picks a slot that was free at the start of the cycle, while the
    // RESPOND clear targets a slot that was valid, so the two writes never collide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            fwd_q        <= 1'b0;
            fwd_prefix_q <= '0;
            fwd_len_q    <= '0;
            qry_prefix_q <= '0;
            qry_len_q    <= '0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            dv_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            fwd_q <= alloc;
            if (alloc) begin
                valid_q[free_idx] <= 1'b1;
                fwd_prefix_q      <= interest_prefix_i;
                fwd_len_q         <= interest_len_i;
            end
            if (clear_slot) valid_q[hit_idx_q] <= 1'b0;
            if (state_q == S_IDLE && prefix_ready_i) begin
                qry_prefix_q <= pit_out_prefix_i;
                qry_len_q    <= pit_out_len_i;
            end
            if (state_q == S_LOOKUP) begin
                hit_q     <= lk_hit;
                hit_idx_q <= lk_idx;
            end
            dv_q   <= capture;
            done_q <= last_byte;
            if (capture) begin
                data_q <= out_data_i;
                cnt_q  <= last_byte ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc) begin
            prefix_q[free_idx] <= interest_prefix_i;
            len_q[free_idx]    <= interest_len_i;
        end
    end
endmodule

// File: tb/tb_pit_table.sv
// Directed bench for pit_table: a set-of-names model predicts every output each cycle,
// and literal checks pin the key timing points.
module tb_pit_table;
    localparam int ENTRIES = 8;
    localparam int DB      = 1024;

    logic        clk = 1'b0;
    logic        rst, iv, pr;
    logic [63:0] ip, pp;
    logic [5:0]  il, pl;
    logic [7:0]  od;
    logic        ready, fib, rej, start, dv, done;
    logic [63:0] pip;
    logic [5:0]  pil;
    logic [7:0]  dout;

    always #5 clk = ~clk;

    pit_table #(.ENTRIES(ENTRIES), .DATA_BYTES(DB)) dut (
        .clk_i(clk), .rst_i(rst),
        .interest_valid_i(iv), .interest_prefix_i(ip), .interest_len_i(il),
        .interest_ready_o(ready), .fib_out_bit_o(fib),
        .pit_in_prefix_o(pip), .pit_in_len_o(pil),
        .prefix_ready_i(pr), .pit_out_prefix_i(pp), .pit_out_len_i(pl),
        .out_data_i(od), .rejected_o(rej), .start_send_to_pit_o(start),
        .data_out_o(dout), .data_out_valid_o(dv), .data_done_o(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef logic [69:0] name_t;
    name_t       tbl[$];
    int          cyc = 0;
    bit          m_fib = 0;
    logic [63:0] m_pp = '0;
    logic [5:0]  m_pl = '0;
    bit          q_act = 0;
    bit          q_hit = 0;
    int          q_t = 0;
    name_t       q_name = '0;
    int          next_idle = 0;
    logic [7:0]  m_byte = '0;
    int          dv_cnt = 0;
    int          done_cnt = 0;

    function automatic bit has(input name_t n);
        foreach (tbl[i]) if (tbl[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        int c;
        c = cyc;
        if (rst) begin
            tbl.delete();
            m_fib = 0; m_pp = '0; m_pl = '0;
            q_act = 0; q_hit = 0; next_idle = c + 1; m_byte = '0;
        end else begin
            if (q_act && c == q_t + 1) begin
                q_hit = has(q_name);
                if (q_hit) next_idle = q_t + 3 + DB;
            end
            m_fib = 0;
            if (iv && tbl.size() < ENTRIES && !has({il, ip})) begin
                tbl.push_back({il, ip});
                m_fib = 1; m_pp = ip; m_pl = il;
            end
            if (q_act && q_hit && c == q_t + 2) begin
                for (int i = 0; i < tbl.size(); i++)
                    if (tbl[i] == q_name) begin
                        tbl.delete(i);
                        break;
                    end
            end
            if (q_act && q_hit && c >= q_t + 3 && c <= q_t + 2 + DB) m_byte = od;
            if (pr && c >= next_idle) begin
                q_act = 1; q_hit = 0; q_t = c; q_name = {pl, pp}; next_idle = c + 3;
            end
        end
        cyc = c + 1;
    end

    always @(negedge clk) begin : compare
        bit e_rej, e_st, e_dv, e_done;
        e_rej  = q_act && cyc == q_t + 2 && !q_hit;
        e_st   = q_act && cyc == q_t + 2 && q_hit;
        e_dv   = q_act && q_hit && cyc >= q_t + 4 && cyc <= q_t + 3 + DB;
        e_done = q_act && q_hit && cyc == q_t + 3 + DB;
        check("interest_ready", ready, tbl.size() < ENTRIES);
        check("fib_out_bit", fib, m_fib);
        check("pit_in_prefix", pip, m_pp);
        check("pit_in_len", pil, m_pl);
        check("rejected", rej, e_rej);
        check("start_send", start, e_st);
        check("data_out_valid", dv, e_dv);
        check("data_done", done, e_done);
        if (e_dv) check("data_out", dout, m_byte);
        if (dv) dv_cnt++;
        if (done) done_cnt++;
    end

    function automatic logic [63:0] pfx(input int i);
        return 64'hA5A5_0000_0000_0001 + 64'(i) * 64'h1111;
    endfunction
    function automatic logic [5:0] len(input int i);
        return 6'(16 + (i % 3));
    endfunction

    task automatic ins(input int i);
        @(posedge clk); #1;
        iv = 1'b1; ip = pfx(i); il = len(i);
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic query(input int i);
        @(posedge clk); #1;
        pr = 1'b1; pp = pfx(i); pl = len(i);
        @(posedge clk); #1;
        pr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_fib"}, fib, 0);
        check({tag, "_pip"}, pip, 0);
        check({tag, "_pil"}, pil, 0);
        check({tag, "_rej"}, rej, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_dv"}, dv, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; pr = 1'b0; ip = '0; il = '0; pp = '0; pl = '0; od = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");

        ins(0);
        check("fwd_pulse", fib, 1);
        check("fwd_prefix", pip, 64'hA5A5_0000_0000_0001);
        check("fwd_len", pil, 6'd16);
        check("ready_after_one", ready, 1);
        ins(0);
        check("dup_no_fwd", fib, 0);

        for (int i = 1; i < ENTRIES; i++) ins(i);
        check("full_ready", ready, 0);
        ins(8);
        check("full_new_refused", fib, 0);
        ins(0);
        check("full_dup_refused", fib, 0);

        query(8);
        @(posedge clk); #1;
        check("miss_rejected", rej, 1);
        check("miss_no_start", start, 0);
        repeat (3) @(posedge clk);

        query(3);
        @(posedge clk); #1;
        check("hit_start", start, 1);
        dv_cnt = 0; done_cnt = 0;
        for (int i = 0; i < DB; i++) begin
            @(posedge clk); #1;
            od = 8'(i);
            if (i == 0) check("slot_freed_ready", ready, 1);
            if (i == 10) begin iv = 1'b1; ip = pfx(3); il = len(3); end
            if (i == 11) begin
                iv = 1'b0;
                check("dup_during_receive_fwd", fib, 1);
                check("data_out_byte10", dout, 8'd10);
            end
        end
        @(posedge clk); #1;
        check("last_done", done, 1);
        check("last_byte", dout, 8'd255);
        @(posedge clk); #1;
        check("dv_count", dv_cnt, DB);
        check("done_count", done_cnt, 1);

        query(5);
        @(posedge clk); #1;
        check("hit2_start", start, 1);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            od = 8'(i);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        query(5);
        @(posedge clk); #1;
        check("after_rst_rejected", rej, 1);
        repeat (2) @(posedge clk);

        // insert lands on the same edge that ends LOOKUP, so the lookup must miss
        @(posedge clk); #1;
        pr = 1'b1; pp = pfx(1); pl = len(1);
        @(posedge clk); #1;
        pr = 1'b0; iv = 1'b1; ip = pfx(1); il = len(1);
        @(posedge clk); #1;
        iv = 1'b0;
        check("insert_vs_lookup_rejected", rej, 1);
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
